ieee_to_fixed_seq: RTL and testbench

//  Parametrised sequential converter. Takes an IEEE-style float (sign, biased exponent,

---
 rtl/ieee_to_fixed_seq.sv | 174 +++++++++++++++++
 tb/tb_ieee_to_fixed_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ieee_to_fixed_seq.sv
// Sequential IEEE-style float to fixed-point converter. A 1-bit-per-cycle shifter normalises the
// significand, and a start/busy/done handshake frames each conversion.
module ieee_to_fixed_seq #(
  parameter int unsigned EXP_W      = 8,
  parameter int unsigned MAN_W      = 8,
  parameter int          BIAS       = 127,
  parameter int unsigned INT_W      = 8,
  parameter int unsigned FRAC_W     = 8,
  parameter int unsigned SIGNED_OUT = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              sign,
  input  logic [EXP_W-1:0]  exponent,
  input  logic [MAN_W-1:0]  mantissa,
  output logic              busy,
  output logic              done,
  output logic              sign_out,
  output logic [INT_W-1:0]  int_part,
  output logic [FRAC_W-1:0] frac_part,
  output logic              overflow,
  output logic              underflow,
  output logic              invalid
);

  localparam int unsigned W     = INT_W + FRAC_W + MAN_W;
  localparam int unsigned PtPos = FRAC_W + MAN_W;
  localparam int unsigned OutW  = INT_W + FRAC_W;
  localparam int unsigned CntW  = $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // Result class decided at load; only KNormal takes its magnitude from the accumulator.
  typedef enum logic [2:0] {KNormal, KZero, KOvf, KInf, KNan, KUnf} kind_e;

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              left_q, left_d;
  logic              sign_l_q, sign_l_d;
  logic              done_q, done_d;
  logic              sign_out_q, sign_out_d;
  logic [INT_W-1:0]  int_q, int_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              inv_q, inv_d;

  int                e_eff;
  int                n_abs;
  logic              exp_ones;
  logic              exp_zero;
  logic [W-1:0]      acc_load;
  logic [OutW-1:0]   mag;
  logic [OutW-1:0]   res;

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    acc_d      = acc_q;
    count_d    = count_q;
    left_d     = left_q;
    sign_l_d   = sign_l_q;
    done_d     = 1'b0;
    sign_out_d = sign_out_q;
    int_d      = int_q;
    frac_d     = frac_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    inv_d      = inv_q;
    mag        = '0;
    res        = '0;

    exp_ones = &exponent;
    exp_zero = (exponent == '0);
    e_eff    = exp_zero ? (1 - BIAS) : (int'(exponent) - BIAS);
    n_abs    = (e_eff < 0) ? -e_eff : e_eff;
    acc_load = '0;
    acc_load[PtPos -: MAN_W+1] = {~exp_zero, mantissa};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          inv_d    = 1'b0;
          sign_l_d = sign;
          acc_d    = acc_load;
          left_d   = (e_eff > 0);
          count_d  = CntW'(n_abs);
          state_d  = StDone;
          if (exp_ones) begin
            kind_d = (mantissa == '0) ? KInf : KNan;
          end else if (exp_zero && mantissa == '0) begin
            kind_d = KZero;
          end else if (e_eff > 0 && n_abs >= int'(INT_W)) begin
            kind_d = KOvf;
          end else if (e_eff < 0 && n_abs > int'(PtPos)) begin
            kind_d = KUnf;
          end else begin
            kind_d = KNormal;
            if (n_abs != 0) state_d = StShift;
          end
        end
      end
      StShift: begin
        acc_d   = left_q ? (acc_q << 1) : (acc_q >> 1);
        count_d = count_q - CntW'(1);
        if (count_q == CntW'(1)) state_d = StDone;
      end
      StDone: begin
        unique case (kind_q)
          KNormal:    mag = acc_q[W-1 -: OutW];
          KOvf, KInf: mag = (SIGNED_OUT != 0) ? {1'b0, {(OutW-1){1'b1}}} : '1;
          default:    mag = '0;
        endcase
        sign_out_d = sign_l_q & (|mag);
        res        = (SIGNED_OUT != 0 && sign_out_d) ? -mag : mag;
        int_d      = res[OutW-1 -: INT_W];
        frac_d     = res[FRAC_W-1:0];
        ovf_d      = (kind_q == KOvf);
        inv_d      = (kind_q == KInf) || (kind_q == KNan);
        unf_d      = (kind_q == KUnf) || (kind_q == KNormal && mag == '0);
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      kind_q     <= KZero;
      acc_q      <= '0;
      count_q    <= '0;
      left_q     <= 1'b0;
      sign_l_q   <= 1'b0;
      done_q     <= 1'b0;
      sign_out_q <= 1'b0;
      int_q      <= '0;
      frac_q     <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      left_q     <= left_d;
      sign_l_q   <= sign_l_d;
      done_q     <= done_d;
      sign_out_q <= sign_out_d;
      int_q      <= int_d;
      frac_q     <= frac_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      inv_q      <= inv_d;
    end
  end

  assign busy      = (state_q == StShift);
  assign done      = done_q;
  assign sign_out  = sign_out_q;
  assign int_part  = int_q;
  assign frac_part = frac_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;

endmodule

// File: tb/tb_ieee_to_fixed_seq.sv
// Bench for ieee_to_fixed_seq: hand-computed vector table, multi-cycle corner sequences, and
// random vectors against a value-level model. A SIGNED_OUT=1 copy runs in lockstep.
module tb_ieee_to_fixed_seq;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       sign = 1'b0;
  logic [7:0] exponent = '0;
  logic [7:0] mantissa = '0;

  logic       busy, done, sign_out, overflow, underflow, invalid;
  logic [7:0] int_part, frac_part;
  logic       s_busy, s_done, s_sign_out, s_overflow, s_underflow, s_invalid;
  logic [7:0] s_int_part, s_frac_part;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  ieee_to_fixed_seq u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .sign(sign), .exponent(exponent),
    .mantissa(mantissa), .busy(busy), .done(done), .sign_out(sign_out), .int_part(int_part),
    .frac_part(frac_part), .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  ieee_to_fixed_seq #(.SIGNED_OUT(1)) u_sdut (
    .clock(clock), .reset_n(reset_n), .start(start), .sign(sign), .exponent(exponent),
    .mantissa(mantissa), .busy(s_busy), .done(s_done), .sign_out(s_sign_out),
    .int_part(s_int_part), .frac_part(s_frac_part), .overflow(s_overflow),
    .underflow(s_underflow), .invalid(s_invalid)
  );

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [7:0]  m;
    logic [7:0]  xi;
    logic [7:0]  xf;
    logic        xso;
    logic [2:0]  xfl;    // {overflow, underflow, invalid}
    int          xlat;   // edges from start edge to done
    int          xbusy;
    logic [15:0] xsres;  // signed-mode {int,frac}
  } vec_t;

  vec_t vecs[14];

  // Captured results of the last conversion
  int          g_lat, g_busy;
  logic [7:0]  g_int, g_frac;
  logic        g_so, g_sso;
  logic [2:0]  g_fl, g_sfl;
  logic [15:0] g_sres;

  task automatic check(input string name, input longint got, input longint expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
    end
  endtask

  task automatic capture();
    g_int  = int_part;
    g_frac = frac_part;
    g_so   = sign_out;
    g_fl   = {overflow, underflow, invalid};
    g_sres = {s_int_part, s_frac_part};
    g_sso  = s_sign_out;
    g_sfl  = {s_overflow, s_underflow, s_invalid};
  endtask

  // Pulse start for one edge and wait (bounded) for done.
  task automatic do_conv(input logic s, input logic [7:0] e, input logic [7:0] m);
    @(negedge clock);
    sign = s; exponent = e; mantissa = m; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    g_busy = busy ? 1 : 0;
    g_lat  = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      #1;
      if (done) begin
        g_lat = c;
        capture();
        break;
      end
      if (busy) g_busy++;
    end
    @(posedge clock);
    #1 check("done_one_cycle", done, 0);
  endtask

  // Value-level reference: |value| * 2^FRAC_W truncated, with saturation and flags.
  function automatic void ref_model(input logic s, input logic [7:0] e, input logic [7:0] m,
                                    input bit smode, output logic [15:0] res, output logic so,
                                    output logic [2:0] fl, output int lat);
    longint sig, scaled;
    int ex, n;
    logic [15:0] mag;
    logic ovf, unf, inv;
    ovf = 1'b0; unf = 1'b0; inv = 1'b0; lat = 1;
    if (e == 8'hFF) begin
      inv = 1'b1;
      mag = (m == 0) ? (smode ? 16'h7FFF : 16'hFFFF) : 16'h0000;
    end else begin
      ex  = (e == 0) ? (1 - 127) : (int'(e) - 127);
      sig = longint'(m) + ((e != 0) ? 256 : 0);
      // FRAC_W == MAN_W, so the scale shift equals the effective exponent
      if (ex > 30)       scaled = longint'(1) << 40;
      else if (ex >= 0)  scaled = sig << ex;
      else if (ex < -40) scaled = 0;
      else               scaled = sig >> (-ex);
      if (scaled >= 65536) begin
        ovf = 1'b1;
        mag = smode ? 16'h7FFF : 16'hFFFF;
      end else begin
        mag = 16'(scaled);
        unf = (sig != 0) && (mag == 0);
      end
      n = (ex < 0) ? -ex : ex;
      if (sig != 0 && ex != 0 && !(ex > 0 && n >= 8) && !(ex < 0 && n > 16)) lat = n + 1;
    end
    so  = s && (mag != 0);
    res = (smode && so) ? -mag : mag;
    fl  = {ovf, unf, inv};
  endfunction

  initial begin
    logic [15:0] xres, xsres;
    logic        xso, xsso;
    logic [2:0]  xfl, xsfl;
    int          xlat;
    int          dones, first, second;
    logic        rs;
    logic [7:0]  re, rm;

    vecs[0]  = '{1'b0, 8'd128, 8'h98, 8'h03, 8'h30, 1'b0, 3'b000, 2, 1, 16'h0330};
    vecs[1]  = '{1'b0, 8'd124, 8'h00, 8'h00, 8'h20, 1'b0, 3'b000, 4, 3, 16'h0020};
    vecs[2]  = '{1'b0, 8'd135, 8'h5A, 8'hFF, 8'hFF, 1'b0, 3'b100, 1, 0, 16'h7FFF};
    vecs[3]  = '{1'b0, 8'd100, 8'h40, 8'h00, 8'h00, 1'b0, 3'b010, 1, 0, 16'h0000};
    vecs[4]  = '{1'b0, 8'd0,   8'h00, 8'h00, 8'h00, 1'b0, 3'b000, 1, 0, 16'h0000};
    vecs[5]  = '{1'b0, 8'd255, 8'h00, 8'hFF, 8'hFF, 1'b0, 3'b001, 1, 0, 16'h7FFF};
    vecs[6]  = '{1'b0, 8'd255, 8'h01, 8'h00, 8'h00, 1'b0, 3'b001, 1, 0, 16'h0000};
    vecs[7]  = '{1'b1, 8'd127, 8'h80, 8'h01, 8'h80, 1'b1, 3'b000, 1, 0, 16'hFE80};
    vecs[8]  = '{1'b0, 8'd134, 8'hFF, 8'hFF, 8'h80, 1'b0, 3'b000, 8, 7, 16'hFF80};
    vecs[9]  = '{1'b0, 8'd111, 8'h00, 8'h00, 8'h00, 1'b0, 3'b010, 17, 16, 16'h0000};
    vecs[10] = '{1'b0, 8'd110, 8'h00, 8'h00, 8'h00, 1'b0, 3'b010, 1, 0, 16'h0000};
    vecs[11] = '{1'b1, 8'd120, 8'hC0, 8'h00, 8'h03, 1'b1, 3'b000, 8, 7, 16'hFFFD};
    vecs[12] = '{1'b0, 8'd0,   8'h80, 8'h00, 8'h00, 1'b0, 3'b010, 1, 0, 16'h0000};
    vecs[13] = '{1'b1, 8'd128, 8'h98, 8'h03, 8'h30, 1'b1, 3'b000, 2, 1, 16'hFCD0};

    // Reset state
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", {int_part, frac_part}, 0);
    check("reset_flags", {overflow, underflow, invalid, sign_out}, 0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      do_conv(vecs[i].s, vecs[i].e, vecs[i].m);
      check($sformatf("v%0d_lat", i), g_lat, vecs[i].xlat);
      check($sformatf("v%0d_busy", i), g_busy, vecs[i].xbusy);
      check($sformatf("v%0d_int", i), g_int, vecs[i].xi);
      check($sformatf("v%0d_frac", i), g_frac, vecs[i].xf);
      check($sformatf("v%0d_sign", i), g_so, vecs[i].xso);
      check($sformatf("v%0d_flags", i), g_fl, vecs[i].xfl);
      check($sformatf("v%0d_sres", i), g_sres, vecs[i].xsres);
      check($sformatf("v%0d_ssign", i), g_sso, vecs[i].xso);
    end

    // start pulsed during SHIFT is ignored
    @(negedge clock);
    sign = 1'b0; exponent = 8'd124; mantissa = 8'h00; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    exponent = 8'd128; mantissa = 8'h98; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    g_lat = 0;
    for (int c = 2; c <= 40; c++) begin
      @(posedge clock);
      #1;
      if (done) begin
        g_lat = c;
        capture();
        break;
      end
    end
    check("ign_lat", g_lat, 4);
    check("ign_result", {g_int, g_frac}, 16'h0020);
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1 if (done) dones++;
    end
    check("ign_no_extra_done", dones, 0);

    // Reset mid-SHIFT discards the conversion
    do_conv(1'b0, 8'd128, 8'h98);
    @(negedge clock);
    exponent = 8'd111; mantissa = 8'h00; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", {int_part, frac_part, s_int_part, s_frac_part}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    do_conv(1'b0, 8'd128, 8'h98);
    check("rst_next_lat", g_lat, 2);
    check("rst_next_result", {g_int, g_frac}, 16'h0330);

    // start held high re-triggers on the IDLE after DONE
    @(negedge clock);
    sign = 1'b0; exponent = 8'd128; mantissa = 8'h98; start = 1'b1;
    @(posedge clock);
    first = 0; second = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      #1;
      if (done && first == 0) first = c;
      else if (done) begin
        second = c;
        start = 1'b0;
        break;
      end
    end
    check("hold_first", first, 2);
    check("hold_gap", second - first, 3);
    repeat (4) @(posedge clock);

    // Random vectors against the reference model
    for (int i = 0; i < 200; i++) begin
      rs = 1'($urandom);
      re = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(105, 136));
      rm = 8'($urandom);
      ref_model(rs, re, rm, 1'b0, xres, xso, xfl, xlat);
      ref_model(rs, re, rm, 1'b1, xsres, xsso, xsfl, xlat);
      do_conv(rs, re, rm);
      check($sformatf("r%0d_lat e=%0d", i, re), g_lat, xlat);
      check($sformatf("r%0d_busy e=%0d", i, re), g_busy, xlat - 1);
      check($sformatf("r%0d_res e=%0d m=%0h", i, re, rm), {g_int, g_frac}, xres);
      check($sformatf("r%0d_sign", i), g_so, xso);
      check($sformatf("r%0d_flags", i), g_fl, xfl);
      check($sformatf("r%0d_sres e=%0d m=%0h", i, re, rm), g_sres, xsres);
      check($sformatf("r%0d_ssign", i), g_sso, xsso);
      check($sformatf("r%0d_sflags", i), g_sfl, xsfl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
